pid_mac_sequencer: RTL and testbench
====================================

Name: pid_mac_sequencer

Overview:
Sequences one PID update of the fan-speed loop through the shared serial multiply-accumulate unit. On each error sample it updates the integral and derivative terms, then issues three chained MAC jobs: Kp·e, Ki·I and Kd·D. It clamps the chained result to a non-negative duty value and handles watchdog timeout and overrun. It sits between the error/sample logic and the serial MAC instance, which it drives and monitors.

Parameters:
N, 4, half data width; all data words are 2N bits, two's complement.
TIMEOUT, 1023, max clk_i cycles to wait for mul_done_i per job before abort.

Ports:
clk_i  in  1  system clock
rstn_i  in  1  synchronous reset, active-low
start_strb_i  in  1  one-cycle pulse; new error sample valid
err_i  in  2N  signed error sample
kp_i  in  2N  signed proportional gain, sampled at accepted start
ki_i  in  2N  signed integral gain, sampled at accepted start
kd_i  in  2N  signed derivative gain, sampled at accepted start
mul_start_o  out  1  one-cycle start strobe to MAC
mul_a_o  out  2N  MAC operand a (gain)
mul_b_o  out  2N  MAC operand b (term)
mul_acc_o  out  2N  MAC accumulator preload
mul_done_i  in  1  MAC done strobe
mul_out_i  in  2N  MAC result, stable after done
duty_o  out  2N  clamped controller output
done_strb_o  out  1  one-cycle pulse when duty_o updated
busy_o  out  1  high in any state except IDLE
timeout_o  out  1  sticky; set on watchdog abort, cleared by next accepted start
overrun_o  out  1  sticky; set on start while busy, cleared only by reset

Behaviour:
- Reset (rstn_i low at posedge): state IDLE. All outputs 0. Integral I, previous error e_prev, and the watchdog counter are 0. Reset mid-job abandons the job and commits nothing.
- States: IDLE, UPDATE, ISSUE_P, WAIT_P, ISSUE_I, WAIT_I, ISSUE_D, WAIT_D, OUTPUT.
- IDLE with start_strb_i: latch err_i, kp_i, ki_i, kd_i; clear timeout_o; go to UPDATE.
- UPDATE (1 cycle): compute I_n = sat(I + e) and D = sat(e − e_prev).
  - sat: clamp to [−2^(2N−1), 2^(2N−1)−1], using a 2N+1-bit intermediate.
  - I_n and D are held in working registers; I and e_prev are unchanged.
- ISSUE_x (1 cycle):
  - mul_start_o = 1.
  - Operands: P: a = Kp, b = e, acc = 0. I: a = Ki, b = I_n, acc = captured result. D: a = Kd, b = D, acc = captured result.
  - Operand outputs are registered and held constant from ISSUE through the end of WAIT.
- WAIT_x: the watchdog counts up from 0. On mul_done_i, capture mul_out_i and go to the next ISSUE, or to OUTPUT after D.
  - A mul_done_i arriving in any non-WAIT state is ignored.
- Watchdog: reaching TIMEOUT in WAIT without done sets timeout_o and returns to IDLE. No commit; duty_o is held; no done strobe.
- OUTPUT (1 cycle):
  - duty_o = 0 if result < 0, else result.
  - done_strb_o = 1.
  - Commit I ← I_n and e_prev ← e.
  - Go to IDLE.
- MAC products and sums wrap modulo 2^(2N); the sequencer does not saturate them. Only I, D and the final sign clamp saturate.
- Sequencer overhead beyond the three MAC latencies: 5 cycles from start to done strobe.
  - UPDATE, ISSUE_P, the two ISSUE hops after done, and OUTPUT.
  - Back-to-back starts are accepted from the cycle after OUTPUT, i.e. once IDLE is re-entered.
- start_strb_i while busy_o = 1: ignored, overrun_o set. A start in the OUTPUT cycle counts as busy.

Decomposition:
- Shared package holds:
  - state encoding constants;
  - the saturating-add helper function;
  - the clog2 helper function, used to size the watchdog counter from TIMEOUT.
- One natural sub-module: pid_term_update. It is combinational plus registers for I_n and D, with saturation. It lets the saturation logic be verified standalone.

Test Plan:
- After reset, Kp=2, Ki=1, Kd=0, err=3 start -> MAC issues (2,3,0), (1,3,6), (0,3,9); duty_o=9, done_strb_o one pulse, busy_o low next cycle.
- Second sample with same gains and err=3 -> I=6, D=0, duty_o=12; exactly 3 mul_start_o pulses per update.
- From reset, Kp=2, Ki=0, Kd=0, err=−5 -> result −10 (0xF6), duty_o=0.
- Ki=1 and I driven to 127 by repeated samples of err=100, then err=10 -> I stays 127 (no wrap to negative).
- Bench model never asserts mul_done_i -> after 1023 WAIT cycles timeout_o=1, state IDLE, duty_o unchanged, next start clears timeout_o and completes normally.
- start_strb_i pulsed during WAIT_I -> overrun_o=1, the in-flight result is unaffected; reset asserted mid-WAIT_D -> all outputs 0, I=0, and a new start computes from clean state.

Source files
------------

// File: rtl/pid_mac_sequencer_pkg.sv
// Shared types and helpers for the PID MAC sequencer.
// Holds the state encoding, the saturating adder and the counter-width helper.
package pid_mac_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_UPDATE,
        ST_ISSUE_P,
        ST_WAIT_P,
        ST_ISSUE_I,
        ST_WAIT_I,
        ST_ISSUE_D,
        ST_WAIT_D,
        ST_OUTPUT
    } state_e;

    // Adds two sign-extended words and clamps to a signed range of 'width' bits (width <= 31).
    function automatic logic signed [31:0] satAdd(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int unsigned        width
    );
        logic signed [31:0] sum;
        logic signed [31:0] maxVal;
        logic signed [31:0] minVal;
        sum    = a + b;
        maxVal = (32'sd1 <<< (width - 1)) - 32'sd1;
        minVal = -(32'sd1 <<< (width - 1));
        if (sum > maxVal) begin
            return maxVal;
        end
        if (sum < minVal) begin
            return minVal;
        end
        return sum;
    endfunction

    function automatic int clog2(input int unsigned value);
        int          result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span = span << 1;
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/pid_mac_sequencer_if.sv
// Bus between the PID sequencer (master) and the shared serial MAC (slave).
interface pid_mac_sequencer_if #(
    parameter int N = 4
);
    logic                  mul_start;
    logic signed [2*N-1:0] mul_a;
    logic signed [2*N-1:0] mul_b;
    logic signed [2*N-1:0] mul_acc;
    logic                  mul_done;
    logic signed [2*N-1:0] mul_out;

    modport master (
        output mul_start, mul_a, mul_b, mul_acc,
        input  mul_done, mul_out
    );

    modport slave (
        input  mul_start, mul_a, mul_b, mul_acc,
        output mul_done, mul_out
    );
endinterface

// File: rtl/pid_term_update.sv
// Computes the saturated next integral and derivative terms and holds them
// for the duration of one PID update.
module pid_term_update
    import pid_mac_sequencer_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  load_i,
    input  logic signed [2*N-1:0] err_i,
    input  logic signed [2*N-1:0] integ_i,
    input  logic signed [2*N-1:0] errPrev_i,
    output logic signed [2*N-1:0] integNext_o,
    output logic signed [2*N-1:0] deriv_o
);
    localparam int DW = 2 * N;

    logic signed [DW-1:0] integNext_d, integNext_q;
    logic signed [DW-1:0] deriv_d, deriv_q;

    always_comb begin
        integNext_d = DW'(satAdd(32'(integ_i), 32'(err_i), DW));
        deriv_d     = DW'(satAdd(32'(err_i), -32'(errPrev_i), DW));
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            integNext_q <= '0;
            deriv_q     <= '0;
        end else if (load_i) begin
            integNext_q <= integNext_d;
            deriv_q     <= deriv_d;
        end
    end

    assign integNext_o = integNext_q;
    assign deriv_o     = deriv_q;

endmodule

// File: rtl/pid_mac_sequencer.sv
// Runs one PID update per error sample as three chained jobs on the shared MAC
// (Kp*e, Ki*I, Kd*D), with watchdog abort and overrun detection.
module pid_mac_sequencer
    import pid_mac_sequencer_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_strb_i,
    input  logic signed [2*N-1:0] err_i,
    input  logic signed [2*N-1:0] kp_i,
    input  logic signed [2*N-1:0] ki_i,
    input  logic signed [2*N-1:0] kd_i,
    pid_mac_sequencer_if.master   mac,
    output logic [2*N-1:0]        duty_o,
    output logic                  done_strb_o,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic                  overrun_o
);
    localparam int DW  = 2 * N;
    localparam int WDW = clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic signed [DW-1:0] err_q, err_d, kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
    logic signed [DW-1:0] integ_q, integ_d, ePrev_q, ePrev_d;
    logic signed [DW-1:0] mulA_q, mulA_d, mulB_q, mulB_d, mulAcc_q, mulAcc_d;
    logic [DW-1:0]        duty_q, duty_d;
    logic                 mulStart_q, mulStart_d, doneStrb_q, doneStrb_d;
    logic                 timeout_q, timeout_d, overrun_q, overrun_d;
    logic [WDW-1:0]       wdog_q, wdog_d;
    logic signed [DW-1:0] integNext, deriv;

    pid_term_update #(.N(N)) u_termUpdate (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .load_i      (state_q == ST_UPDATE),
        .err_i       (err_q),
        .integ_i     (integ_q),
        .errPrev_i   (ePrev_q),
        .integNext_o (integNext),
        .deriv_o     (deriv)
    );

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        kp_d       = kp_q;
        ki_d       = ki_q;
        kd_d       = kd_q;
        integ_d    = integ_q;
        ePrev_d    = ePrev_q;
        mulA_d     = mulA_q;
        mulB_d     = mulB_q;
        mulAcc_d   = mulAcc_q;
        duty_d     = duty_q;
        mulStart_d = 1'b0;
        doneStrb_d = 1'b0;
        timeout_d  = timeout_q;
        overrun_d  = overrun_q;
        wdog_d     = wdog_q;

        if (start_strb_i && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_strb_i) begin
                    err_d     = err_i;
                    kp_d      = kp_i;
                    ki_d      = ki_i;
                    kd_d      = kd_i;
                    timeout_d = 1'b0;
                    state_d   = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                mulA_d     = kp_q;
                mulB_d     = err_q;
                mulAcc_d   = '0;
                mulStart_d = 1'b1;
                wdog_d     = '0;
                state_d    = ST_ISSUE_P;
            end
            ST_ISSUE_P: state_d = ST_WAIT_P;
            ST_ISSUE_I: state_d = ST_WAIT_I;
            ST_ISSUE_D: state_d = ST_WAIT_D;
            ST_WAIT_P, ST_WAIT_I, ST_WAIT_D: begin
                // The captured result becomes the next job's accumulator preload.
                if (mac.mul_done) begin
                    mulAcc_d   = mac.mul_out;
                    mulStart_d = 1'b1;
                    wdog_d     = '0;
                    if (state_q == ST_WAIT_P) begin
                        mulA_d  = ki_q;
                        mulB_d  = integNext;
                        state_d = ST_ISSUE_I;
                    end else if (state_q == ST_WAIT_I) begin
                        mulA_d  = kd_q;
                        mulB_d  = deriv;
                        state_d = ST_ISSUE_D;
                    end else begin
                        mulStart_d = 1'b0;
                        duty_d     = mac.mul_out[DW-1] ? '0 : mac.mul_out;
                        doneStrb_d = 1'b1;
                        state_d    = ST_OUTPUT;
                    end
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_OUTPUT: begin
                integ_d = integNext;
                ePrev_d = err_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            err_q      <= '0;
            kp_q       <= '0;
            ki_q       <= '0;
            kd_q       <= '0;
            integ_q    <= '0;
            ePrev_q    <= '0;
            mulA_q     <= '0;
            mulB_q     <= '0;
            mulAcc_q   <= '0;
            duty_q     <= '0;
            mulStart_q <= 1'b0;
            doneStrb_q <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            kp_q       <= kp_d;
            ki_q       <= ki_d;
            kd_q       <= kd_d;
            integ_q    <= integ_d;
            ePrev_q    <= ePrev_d;
            mulA_q     <= mulA_d;
            mulB_q     <= mulB_d;
            mulAcc_q   <= mulAcc_d;
            duty_q     <= duty_d;
            mulStart_q <= mulStart_d;
            doneStrb_q <= doneStrb_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
            wdog_q     <= wdog_d;
        end
    end

    assign mac.mul_start = mulStart_q;
    assign mac.mul_a     = mulA_q;
    assign mac.mul_b     = mulB_q;
    assign mac.mul_acc   = mulAcc_q;
    assign duty_o        = duty_q;
    assign done_strb_o   = doneStrb_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign timeout_o     = timeout_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_pid_mac_sequencer.sv
// Testbench for pid_mac_sequencer: a behavioural serial MAC answers each job after
// a random latency, and an arithmetic PID model predicts every job and duty value.
module tb_pid_mac_sequencer;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] acc;
    } op_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       startStrb;
    logic [7:0] errIn, kpIn, kiIn, kdIn;
    logic [7:0] duty;
    logic       doneStrb, busy, timeoutFlag, overrunFlag;

    op_t opQ[$];
    int  assertCount = 0;
    int  failCount   = 0;
    int  refI        = 0;
    int  refEprev    = 0;
    int  refDuty     = 0;
    bit  macEnabled  = 1'b1;
    int  macLatency  = 0;

    pid_mac_sequencer_if #(.N(4)) mac ();

    pid_mac_sequencer #(.N(4), .TIMEOUT(1023)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .start_strb_i (startStrb),
        .err_i        (errIn),
        .kp_i         (kpIn),
        .ki_i         (kiIn),
        .kd_i         (kdIn),
        .mac          (mac),
        .duty_o       (duty),
        .done_strb_o  (doneStrb),
        .busy_o       (busy),
        .timeout_o    (timeoutFlag),
        .overrun_o    (overrunFlag)
    );

    always #5 clk = ~clk;

    // Serial MAC stand-in: logs each job and answers with a*b+acc mod 256 after a latency.
    initial begin : macModel
        int         countdown;
        logic [7:0] res;
        bit         pending;
        op_t        op;
        countdown    = 0;
        res          = '0;
        pending      = 1'b0;
        mac.mul_done = 1'b0;
        mac.mul_out  = '0;
        forever begin
            @(posedge clk);
            #1;
            mac.mul_done = 1'b0;
            if (rstn !== 1'b1) begin
                pending = 1'b0;
            end else if (pending) begin
                countdown--;
                if (countdown <= 0) begin
                    mac.mul_done = 1'b1;
                    mac.mul_out  = res;
                    pending      = 1'b0;
                end
            end else if (mac.mul_start === 1'b1) begin
                op.a   = mac.mul_a;
                op.b   = mac.mul_b;
                op.acc = mac.mul_acc;
                opQ.push_back(op);
                if (macEnabled) begin
                    pending   = 1'b1;
                    countdown = (macLatency > 0) ? macLatency : int'($urandom_range(1, 5));
                    res       = 8'(int'(mac.mul_a) * int'(mac.mul_b) + int'(mac.mul_acc));
                end
            end
        end
    end

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int wrap8(input int v);
        int r;
        r = v & 255;
        if (r > 127) r = r - 256;
        return r;
    endfunction

    function automatic logic [31:0] b8(input int v);
        logic [7:0] t;
        t = v[7:0];
        return {24'd0, t};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int e, input int kp, input int ki, input int kd);
        errIn     = 8'(e);
        kpIn      = 8'(kp);
        kiIn      = 8'(ki);
        kdIn      = 8'(kd);
        startStrb = 1'b1;
        @(negedge clk);
        startStrb = 1'b0;
    endtask

    task automatic doReset();
        rstn      = 1'b0;
        startStrb = 1'b0;
        errIn     = '0;
        kpIn      = '0;
        kiIn      = '0;
        kdIn      = '0;
        repeat (3) @(negedge clk);
        rstn     = 1'b1;
        refI     = 0;
        refEprev = 0;
        refDuty  = 0;
        @(negedge clk);
    endtask

    task automatic waitOps(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (opQ.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic waitDone(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (doneStrb === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // mode 0: normal update; 1: extra start during WAIT_I; 2: reset during WAIT_D.
    task automatic runSample(input string tag, input int e, input int kp, input int ki, input int kd, input int mode);
        int iN, d, r1, r2, r3, expDuty;
        int expA[3], expB[3], expAcc[3];
        bit ok;
        iN      = sat8(refI + e);
        d       = sat8(e - refEprev);
        r1      = wrap8(kp * e);
        r2      = wrap8(ki * iN + r1);
        r3      = wrap8(kd * d + r2);
        expDuty = (r3 < 0) ? 0 : r3;
        expA    = '{kp, ki, kd};
        expB    = '{e, iN, d};
        expAcc  = '{0, r1, r2};
        opQ.delete();
        applyStimulus(e, kp, ki, kd);
        checkOutput({tag, " busy after start"}, 32'(busy), 1);
        checkOutput({tag, " timeout cleared"}, 32'(timeoutFlag), 0);
        if (mode != 0) begin
            waitOps((mode == 1) ? 2 : 3, ok);
            checkOutput({tag, " reached issue"}, 32'(ok), 1);
            @(negedge clk);
        end
        if (mode == 2) begin
            rstn = 1'b0;
            repeat (2) @(negedge clk);
            rstn = 1'b1;
            @(negedge clk);
            checkOutput({tag, " outputs cleared"},
                        32'({duty, doneStrb, busy, timeoutFlag, overrunFlag}), 0);
            checkOutput({tag, " mac bus cleared"},
                        32'({mac.mul_start, mac.mul_a, mac.mul_b, mac.mul_acc}), 0);
            refI     = 0;
            refEprev = 0;
            refDuty  = 0;
        end else begin
            if (mode == 1) begin
                startStrb = 1'b1;
                errIn     = 8'(e + 37);
                kpIn      = 8'(kp + 1);
                @(negedge clk);
                startStrb = 1'b0;
                checkOutput({tag, " overrun set"}, 32'(overrunFlag), 1);
            end
            waitDone(ok);
            checkOutput({tag, " done seen"}, 32'(ok), 1);
            if (ok) begin
                checkOutput({tag, " duty"}, 32'(duty), b8(expDuty));
                checkOutput({tag, " mac jobs"}, 32'(opQ.size()), 3);
                if (opQ.size() == 3) begin
                    for (int k = 0; k < 3; k++) begin
                        checkOutput({tag, $sformatf(" job%0d a", k)}, 32'(opQ[k].a), b8(expA[k]));
                        checkOutput({tag, $sformatf(" job%0d b", k)}, 32'(opQ[k].b), b8(expB[k]));
                        checkOutput({tag, $sformatf(" job%0d acc", k)}, 32'(opQ[k].acc), b8(expAcc[k]));
                    end
                end
            end
            @(negedge clk);
            checkOutput({tag, " done single pulse"}, 32'(doneStrb), 0);
            checkOutput({tag, " idle after done"}, 32'(busy), 0);
            refI     = iN;
            refEprev = e;
            refDuty  = expDuty;
        end
    endtask

    initial begin : mainSequence
        int  waitCount;
        bit  sawDone;
        bit  seen;

        doReset();
        checkOutput("reset outputs", 32'({duty, doneStrb, busy, timeoutFlag, overrunFlag}), 0);
        checkOutput("reset mac bus", 32'({mac.mul_start, mac.mul_a, mac.mul_b, mac.mul_acc}), 0);

        runSample("first", 3, 2, 1, 0, 0);
        checkOutput("first duty literal", 32'(duty), 9);
        runSample("second", 3, 2, 1, 0, 0);
        checkOutput("second duty literal", 32'(duty), 12);

        doReset();
        runSample("negative", -5, 2, 0, 0, 0);
        checkOutput("negative clamps to zero", 32'(duty), 0);

        doReset();
        runSample("isat a", 100, 0, 1, 0, 0);
        runSample("isat b", 100, 0, 1, 0, 0);
        runSample("isat c", 10, 0, 1, 0, 0);
        checkOutput("integral held at max", 32'(duty), 127);
        runSample("dsat low", -128, 0, 0, 1, 0);
        runSample("dsat high", 127, 0, 0, 1, 0);
        checkOutput("derivative held at max", 32'(duty), 127);

        macLatency = 0;
        for (int i = 0; i < 24; i++) begin
            runSample($sformatf("random%0d", i),
                      int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                      int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 0);
        end

        macEnabled = 1'b0;
        opQ.delete();
        applyStimulus(11, 1, 1, 1);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mac.mul_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("timeout job issued", 32'(seen), 1);
        waitCount = 0;
        sawDone   = 1'b0;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            if (doneStrb === 1'b1) sawDone = 1'b1;
            if (timeoutFlag === 1'b1) begin
                waitCount = k;
                break;
            end
        end
        checkOutput("timeout wait length", 32'(waitCount), 1024);
        checkOutput("timeout flag", 32'(timeoutFlag), 1);
        checkOutput("timeout idle", 32'(busy), 0);
        checkOutput("timeout duty held", 32'(duty), b8(refDuty));
        checkOutput("timeout no done", 32'(sawDone), 0);
        checkOutput("timeout single job", 32'(opQ.size()), 1);
        macEnabled = 1'b1;
        runSample("after timeout", 20, 3, 1, 2, 0);

        macLatency = 4;
        runSample("overrun", 9, 5, -2, 3, 1);
        macLatency = 0;
        runSample("post overrun", -7, 4, 2, 1, 0);
        checkOutput("overrun sticky", 32'(overrunFlag), 1);

        macLatency = 6;
        runSample("reset in WAIT_D", 40, 2, 3, 1, 2);
        macLatency = 0;
        runSample("clean start", 7, 1, 2, 3, 0);
        checkOutput("clean start duty literal", 32'(duty), 42);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
